// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the buffered UART receiver:
//     - OVERSAMPLE : number of sample ticks per serial bit (16x)
//     - rx_state_t : receiver FSM state encoding
//     - calc_div   : clk cycles per oversample tick, CLK_HZ / (BAUD * 16)
//
//   Configuration macro: UART_RX_PARITY_EN
//     When defined, the PARITY state exists in the state enum.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

  // Integer division as specified; a zero result (baud too fast for the
  // clock) is clamped to 1 so the divider still produces a tick every cycle.
  function automatic int calc_div(input int clk_hz, input int baud);
    int div;
    div = clk_hz / (baud * OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO with show-ahead read: rdata always presents the head
//   entry (zero when empty). Push and pop in the same cycle both take effect,
//   including when full. Pop on empty is ignored.
//
//   Parameters : WIDTH (data bits), DEPTH (entries, power of two >= 2)
//   Ports      : clk, rst (async, active high)
//                push, wdata      - write side (ignored when full unless popping)
//                pop, rdata       - read side (show-ahead)
//                count            - occupancy, 0..DEPTH
//                full, empty      - status flags
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; only pointers and count do. The
  // read port is forced to zero while empty so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// -----------------------------------------------------------------------------
// uart_rx_buffered
//   UART receiver (16x oversampling, LSB first, 1 stop bit) feeding a
//   show-ahead FIFO of received frames.
//
//   Parameters : CLK_HZ, BAUD, DATA_BITS (5..8), FIFO_DEPTH (power of two),
//                PARITY_ODD (0 = even, 1 = odd; parity builds only)
//   Ports      : clk, rst (async, active high)
//                RsRx      - serial line, idle high, asynchronous
//                rd_en     - pop FIFO head (ignored when valid = 0)
//                data_out  - FIFO head, show-ahead
//                valid     - FIFO non-empty
//                full      - FIFO full
//                count     - FIFO occupancy
//                frame_err - 1-clk pulse on a low stop bit (frame dropped)
//                overrun   - 1-clk pulse when a good frame finds the FIFO full
//                parity_err- 1-clk pulse on parity mismatch (parity builds only)
//
//   Configuration macro: UART_RX_PARITY_EN
//     Defined   : DATA_BITS + parity + 1 stop; PARITY state and parity_err exist.
//     Undefined : DATA_BITS + 1 stop, no parity logic at all.
// -----------------------------------------------------------------------------
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RsRx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Start bit is rechecked at its centre (8 ticks in); every later sample is
  // a full bit (16 ticks) after the previous one.
  localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Oversample tick generator: free-running, wraps at DIV-1
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RsRx};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t            state_q,      state_d;
  logic [3:0]           sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic                 push;
  logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_flag;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    push         = 1'b0;
    frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_flag  = 1'b0;
`endif

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end

        START: begin
          if (sample_cnt_q == MID_SAMPLE) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            // High at the start-bit centre means the low level was a glitch.
            state_d      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end

        DATA: begin
          if (sample_cnt_q == LAST_SAMPLE) begin
            sample_cnt_d = '0;
            shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_cnt_q == LAST_SAMPLE) begin
            sample_cnt_d = '0;
            // XOR of data and parity bit is 0 for even, 1 for odd parity.
            parity_bad_d = ((^shift_q) ^ rx_s) != (PARITY_ODD != 0);
            state_d      = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
`endif

        STOP: begin
          if (sample_cnt_q == LAST_SAMPLE) begin
            sample_cnt_d = '0;
            state_d      = IDLE;
`ifdef UART_RX_PARITY_EN
            parity_flag  = parity_bad_q;
            push         = rx_s && !parity_bad_q;
`else
            push         = rx_s;
`endif
            frame_bad    = !rx_s;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end

        default: begin
          state_d      = IDLE;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------------
  logic fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (rd_en),
    .rdata (data_out),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign valid = !fifo_empty;

  // ---------------------------------------------------------------------------
  // Error pulses: registered so they line up with the FIFO update that the
  // same stop-sample edge would have caused.
  // ---------------------------------------------------------------------------
  logic frame_err_q;
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      // A coinciding pop makes room, so only a push with no pop is dropped.
      overrun_q   <= push && full && !(rd_en && valid);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_flag;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_buffered
//   Directed bench for uart_rx_buffered. Runs with a small divider
//   (CLK_HZ=1_600_000, BAUD=25_000 -> 4 clk per tick, 64 clk per bit) so the
//   whole sequence stays short. Builds with or without UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int CLK_HZ     = 1_600_000;
  localparam int BAUD       = 25_000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;
  localparam int DIV        = 4;
  localparam int BIT        = 16 * DIV;
  localparam int GAP        = 2 * BIT;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       RsRx  = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  int   cyc            = 0;
  int   stop_start_cyc = 0;
  int   last_push_off  = -1;
  int   fe_cnt         = 0;
  int   ov_cnt         = 0;
  int   pe_cnt         = 0;
  logic [2:0] count_prev = '0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  event stop_ev;

  uart_rx_buffered #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RsRx      (RsRx),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .valid     (valid),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, pulse-width checks and push timing, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
    if (fe_prev) begin
      checks++;
      if (frame_err !== 1'b0) begin
        errors++;
        $display("FAIL frame_err_width: got %b for a 2nd clk, expected 0", frame_err);
      end
    end
    if (ov_prev) begin
      checks++;
      if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL overrun_width: got %b for a 2nd clk, expected 0", overrun);
      end
    end
    if (count > count_prev) last_push_off = cyc - stop_start_cyc;
    fe_prev    = (frame_err === 1'b1);
    ov_prev    = (overrun === 1'b1);
    count_prev = count;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 clk, expected to finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input logic b);
    RsRx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic bad_par);
`ifdef UART_RX_PARITY_EN
    logic par;
    par = (^data) ^ (PARITY_ODD != 0) ^ bad_par;
`endif
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    RsRx           = stop_bit;
    stop_start_cyc = cyc;
    ->stop_ev;
    repeat (BIT) @(negedge clk);
    RsRx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_single();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h35, 1'b1, 1'b0);
    checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
    checks++; if (data_out !== 8'h35) begin errors++; $display("FAIL single_data: got %h expected 35", data_out); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    // Stop sample lands 35..38 clk into the stop bit; push visible right after.
    checks++;
    if (last_push_off < 32 || last_push_off > 44) begin
      errors++; $display("FAIL single_latency: got %0d clk expected 32..44", last_push_off);
    end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL single_no_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    pop();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    // Reads on an empty FIFO are ignored.
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL empty_read_count: got %0d expected 0", count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL empty_read_data: got %h expected 00", data_out); end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    RsRx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    RsRx = 1'b1;
    repeat (GAP) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", valid); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    checks++; if (ov_cnt !== ov0) begin errors++; $display("FAIL glitch_ov: got %0d pulses expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL ovr_full4: got %b expected 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovr_count4: got %0d expected 4", count); end
    send_frame(8'h05, 1'b1, 1'b0);
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    checks++; if (count !== 3'd4)     begin errors++; $display("FAIL ovr_count5: got %0d expected 4", count); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL ovr_pop%0d: got %h expected %h", i, data_out, exp); end
      pop();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: got valid %b expected 0", valid); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL ovr_not_full: got %b expected 0", full); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL ferr_count: got %0d expected 0", count); end
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL ferr_next_data: got %h expected 5a", data_out); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", count); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_next_fe: got %0d pulses expected 1", fe_cnt - fe0); end
    pop();
  endtask

  task automatic test_simul();
    int ov0, off;
    logic [7:0] popped;
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h55};
    popped = '0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_full: got %b expected 1", full); end
    // Frames start on the same divider phase, so the push of 0x55 falls the
    // same number of clk into its stop bit as the push of 0x44 did.
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        @(stop_ev);
        off = (last_push_off < 2) ? 2 : last_push_off;
        repeat (off - 1) @(negedge clk);
        popped = data_out;
        rd_en  = 1'b1;
        @(negedge clk);
        rd_en  = 1'b0;
      end
    join
    checks++; if (ov_cnt !== ov0)   begin errors++; $display("FAIL simul_no_ovr: got %0d pulses expected 0", ov_cnt - ov0); end
    checks++; if (count !== 3'd4)   begin errors++; $display("FAIL simul_count: got %0d expected 4", count); end
    checks++; if (popped !== 8'h11) begin errors++; $display("FAIL simul_popped: got %h expected 11", popped); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== exp[i]) begin errors++; $display("FAIL simul_pop%0d: got %h expected %h", i, data_out, exp[i]); end
      pop();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got valid %b expected 0", valid); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int fe0;
    d = 8'h77;
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    RsRx = d[3];
    repeat (BIT / 2) @(negedge clk);
    rst  = 1'b1;
    RsRx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data_out); end
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale: got valid %b expected 0", valid); end
    send_frame(8'h33, 1'b1, 1'b0);
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", count); end
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL rstmid_next_data: got %h expected 33", data_out); end
    checks++; if (fe_cnt !== fe0)     begin errors++; $display("FAIL rstmid_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    pop();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    // 0x07 has three ones; even parity requires 1, so sending 0 is an error.
    send_frame(8'h07, 1'b1, 1'b1);
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_pulse: got %0d pulses expected 1", pe_cnt - pe0); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL parity_drop: got %0d expected 0", count); end
    send_frame(8'h07, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h07) begin errors++; $display("FAIL parity_good_data: got %h expected 07", data_out); end
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_good_pe: got %0d pulses expected 1", pe_cnt - pe0); end
    pop();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_simul();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
